// File: rtl/render_pkg.sv
// Shared rendering definitions: screen geometry, color/coordinate types and
// palette constants used by both the pixel renderer and the raster scanner.
package render_pkg;

    localparam int SCREEN_WIDTH  = 400;
    localparam int SCREEN_HEIGHT = 700;
    localparam int COLOR_W       = 24;
    localparam int COORD_W       = 32;

    typedef logic [COLOR_W-1:0] color_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam color_t COLOR_BACKGROUND = 24'hF8F4E8;
    localparam color_t COLOR_DOODLE     = 24'h7CB342;
    localparam color_t COLOR_BLOCK      = 24'h43A047;

    // Pack 8-bit channels into an RGB 8:8:8 color word.
    function automatic color_t rgb(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {r, g, b};
    endfunction

endpackage

// File: rtl/scan_counter.sv
// Row-major x/y raster counter. x advances fastest; the last pixel of the
// frame wraps both coordinates back to the origin.
module scan_counter #(
    parameter int WIDTH   = 400,
    parameter int HEIGHT  = 700,
    parameter int COORD_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_en,
    output logic [COORD_W-1:0] o_x,
    output logic [COORD_W-1:0] o_y,
    output logic               o_eol,
    output logic               o_last
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);

    logic [COORD_W-1:0] r_x;
    logic [COORD_W-1:0] r_y;

    assign o_x    = r_x;
    assign o_y    = r_y;
    assign o_eol  = (r_x == X_MAX);
    assign o_last = (r_x == X_MAX) && (r_y == Y_MAX);

    // Advance the coordinate pair on enable, wrapping at row and frame ends.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_x <= '0;
            r_y <= '0;
        end else if (i_en) begin
            if (o_last) begin
                r_x <= '0;
                r_y <= '0;
            end else if (o_eol) begin
                r_x <= '0;
                r_y <= r_y + ONE;
            end else begin
                r_x <= r_x + ONE;
            end
        end else begin
            r_x <= r_x;
            r_y <= r_y;
        end
    end

endmodule

// File: rtl/raster_scan_out.sv
// Raster scanner: presents scan coordinates to the combinational renderer,
// captures the returned color into a single valid/ready output register and
// walks one full frame per frame_start request.
module raster_scan_out
    import render_pkg::*;
#(
    parameter int SCREEN_WIDTH  = render_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = render_pkg::SCREEN_HEIGHT,
    parameter int COLOR_W       = render_pkg::COLOR_W,
    parameter int COORD_W       = render_pkg::COORD_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               frame_start,
    output logic [COORD_W-1:0] scan_x,
    output logic [COORD_W-1:0] scan_y,
    input  logic [COLOR_W-1:0] color_in,
    output logic [COLOR_W-1:0] pix_color,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               pix_sof,
    output logic               pix_eol,
    output logic               pix_eof,
    output logic               pix_valid,
    input  logic               pix_ready,
    output logic               busy,
    output logic               frame_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t             r_state;
    logic [COLOR_W-1:0] r_pix_color;
    logic [COORD_W-1:0] r_pix_x;
    logic [COORD_W-1:0] r_pix_y;
    logic               r_pix_sof;
    logic               r_pix_eol;
    logic               r_pix_eof;
    logic               r_pix_valid;
    logic               r_busy;
    logic               r_frame_done;

    logic [COORD_W-1:0] w_scan_x;
    logic [COORD_W-1:0] w_scan_y;
    logic               w_eol;
    logic               w_last;
    logic               w_sof;
    logic               w_capture;

    // The output register may be refilled when empty or being emptied this cycle.
    assign w_capture = (r_state == ST_SCAN) && (!r_pix_valid || pix_ready);
    assign w_sof     = (w_scan_x == '0) && (w_scan_y == '0);

    scan_counter #(
        .WIDTH   (SCREEN_WIDTH),
        .HEIGHT  (SCREEN_HEIGHT),
        .COORD_W (COORD_W)
    ) u_scan_counter (
        .clk    (clk),
        .reset  (reset),
        .i_en   (w_capture),
        .o_x    (w_scan_x),
        .o_y    (w_scan_y),
        .o_eol  (w_eol),
        .o_last (w_last)
    );

    // Frame FSM plus the pixel output register; everything here holds under back-pressure.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_pix_color  <= '0;
            r_pix_x      <= '0;
            r_pix_y      <= '0;
            r_pix_sof    <= 1'b0;
            r_pix_eol    <= 1'b0;
            r_pix_eof    <= 1'b0;
            r_pix_valid  <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (frame_start) begin
                        r_state <= ST_SCAN;
                        r_busy  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (w_capture) begin
                        r_pix_color <= color_in;
                        r_pix_x     <= w_scan_x;
                        r_pix_y     <= w_scan_y;
                        r_pix_sof   <= w_sof;
                        r_pix_eol   <= w_eol;
                        r_pix_eof   <= w_last;
                        r_pix_valid <= 1'b1;
                        if (w_last) begin
                            r_state <= ST_DRAIN;
                        end else begin
                            r_state <= ST_SCAN;
                        end
                    end else begin
                        r_state <= ST_SCAN;
                    end
                end
                ST_DRAIN: begin
                    if (r_pix_valid && pix_ready) begin
                        r_pix_valid  <= 1'b0;
                        r_state      <= ST_IDLE;
                        r_busy       <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_pix_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign scan_x     = w_scan_x;
    assign scan_y     = w_scan_y;
    assign pix_color  = r_pix_color;
    assign pix_x      = r_pix_x;
    assign pix_y      = r_pix_y;
    assign pix_sof    = r_pix_sof;
    assign pix_eol    = r_pix_eol;
    assign pix_eof    = r_pix_eof;
    assign pix_valid  = r_pix_valid;
    assign busy       = r_busy;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_raster_scan_out.sv
// Directed bench for raster_scan_out on a 4x3 screen with a coordinate-echo renderer stub.
module tb_raster_scan_out;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int CW = 24;
    localparam int XW = 32;
    localparam int NPIX = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          frame_start = 1'b0;
    logic [XW-1:0] scan_x, scan_y;
    logic [CW-1:0] color_in;
    logic [CW-1:0] pix_color;
    logic [XW-1:0] pix_x, pix_y;
    logic          pix_sof, pix_eol, pix_eof, pix_valid;
    logic          pix_ready = 1'b0;
    logic          busy, frame_done;

    int errors = 0;
    int checks = 0;

    raster_scan_out #(
        .SCREEN_WIDTH (W),
        .SCREEN_HEIGHT(H),
        .COLOR_W      (CW),
        .COORD_W      (XW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_start(frame_start),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .color_in   (color_in),
        .pix_color  (pix_color),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_sof    (pix_sof),
        .pix_eol    (pix_eol),
        .pix_eof    (pix_eof),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Renderer stub: color echoes the coordinates.
    assign color_in = {8'h00, scan_y[7:0], scan_x[7:0]};

    always #5 clk = ~clk;

    typedef struct {
        logic [XW-1:0] x;
        logic [XW-1:0] y;
        logic [CW-1:0] color;
        logic          sof;
        logic          eol;
        logic          eof;
    } vec_t;

    vec_t tbl[NPIX];

    function automatic vec_t mkv(input int x, input int y, input logic [CW-1:0] c,
                                 input logic s, input logic l, input logic f);
        vec_t v;
        v.x = XW'(x); v.y = XW'(y); v.color = c; v.sof = s; v.eol = l; v.eof = f;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // mode 0: ready high; 1: ready pattern 1,0,0,1; 2: ready low 3 cycles on the eof pixel.
    // pulse_at >= 0: pulse frame_start while beat pulse_at is on the output.
    task automatic stream(input int mode, input int pulse_at,
                          output int beats, output int dones, output int cycles);
        logic          prev_stall;
        logic [XW-1:0] psx, psy;
        logic          pulsed;
        int            eof_stall;
        logic          rdy;
        logic [1:0]    pat;
        beats = 0; dones = 0; cycles = 0;
        prev_stall = 1'b0; psx = '0; psy = '0; pulsed = 1'b0; eof_stall = 0;
        pat = 2'b00;
        frame_start = 1'b1;
        pix_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        chk("no_valid_first_cycle", {63'd0, pix_valid}, 64'd0);
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (prev_stall) begin
                chk("stall_scan_x", {32'd0, scan_x}, {32'd0, psx});
                chk("stall_scan_y", {32'd0, scan_y}, {32'd0, psy});
            end
            if (pix_valid) begin
                if (beats < NPIX) begin
                    chk("pix_x",     {32'd0, pix_x}, {32'd0, tbl[beats].x});
                    chk("pix_y",     {32'd0, pix_y}, {32'd0, tbl[beats].y});
                    chk("pix_color", {40'd0, pix_color}, {40'd0, tbl[beats].color});
                    chk("pix_flags", {61'd0, pix_sof, pix_eol, pix_eof},
                        {61'd0, tbl[beats].sof, tbl[beats].eol, tbl[beats].eof});
                end else begin
                    chk("extra_beat", 64'(beats), 64'(NPIX - 1));
                end
            end
            chk("busy_in_frame", {63'd0, busy}, 64'd1);
            pat = 2'(cyc % 4);
            case (mode)
                1: rdy = (pat == 2'd0) || (pat == 2'd3);
                2: begin
                    if (pix_valid && beats == NPIX - 1 && eof_stall < 3) begin
                        rdy = 1'b0;
                        eof_stall++;
                    end else begin
                        rdy = 1'b1;
                    end
                end
                default: rdy = 1'b1;
            endcase
            pix_ready = rdy;
            if (pulse_at >= 0 && !pulsed && pix_valid && beats == pulse_at) begin
                frame_start = 1'b1;
                pulsed = 1'b1;
            end else begin
                frame_start = 1'b0;
            end
            prev_stall = pix_valid && !rdy;
            psx = scan_x;
            psy = scan_y;
            if (pix_valid && rdy) beats++;
            @(negedge clk);
            frame_start = 1'b0;
            cycles = cyc + 1;
            if (frame_done) begin
                dones++;
                chk("busy_low_at_done", {63'd0, busy}, 64'd0);
                chk("valid_low_at_done", {63'd0, pix_valid}, 64'd0);
                break;
            end
        end
        if (dones == 0) chk("frame_done_timeout", 64'd0, 64'd1);
        pix_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (frame_done) dones++;
            chk("idle_after_frame", {62'd0, busy, pix_valid}, 64'd0);
        end
    endtask

    int beats, dones, cycles;

    initial begin
        tbl[0]  = mkv(0, 0, 24'h000000, 1'b1, 1'b0, 1'b0);
        tbl[1]  = mkv(1, 0, 24'h000001, 1'b0, 1'b0, 1'b0);
        tbl[2]  = mkv(2, 0, 24'h000002, 1'b0, 1'b0, 1'b0);
        tbl[3]  = mkv(3, 0, 24'h000003, 1'b0, 1'b1, 1'b0);
        tbl[4]  = mkv(0, 1, 24'h000100, 1'b0, 1'b0, 1'b0);
        tbl[5]  = mkv(1, 1, 24'h000101, 1'b0, 1'b0, 1'b0);
        tbl[6]  = mkv(2, 1, 24'h000102, 1'b0, 1'b0, 1'b0);
        tbl[7]  = mkv(3, 1, 24'h000103, 1'b0, 1'b1, 1'b0);
        tbl[8]  = mkv(0, 2, 24'h000200, 1'b0, 1'b0, 1'b0);
        tbl[9]  = mkv(1, 2, 24'h000201, 1'b0, 1'b0, 1'b0);
        tbl[10] = mkv(2, 2, 24'h000202, 1'b0, 1'b0, 1'b0);
        tbl[11] = mkv(3, 2, 24'h000203, 1'b0, 1'b1, 1'b1);

        // Reset, then idle.
        reset = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("rst_scan", {scan_x, scan_y}, 64'd0);
        chk("rst_pix_xy", {pix_x, pix_y}, 64'd0);
        chk("rst_color", {40'd0, pix_color}, 64'd0);
        chk("rst_flags", {58'd0, pix_sof, pix_eol, pix_eof, pix_valid, busy, frame_done}, 64'd0);

        // Full-rate frame.
        stream(0, -1, beats, dones, cycles);
        chk("f0_beats", 64'(beats), 64'(NPIX));
        chk("f0_dones", 64'(dones), 64'd1);
        chk("f0_cycles", 64'(cycles), 64'(NPIX + 1));

        // Toggling ready.
        stream(1, -1, beats, dones, cycles);
        chk("f1_beats", 64'(beats), 64'(NPIX));
        chk("f1_dones", 64'(dones), 64'd1);

        // frame_start while busy is ignored.
        stream(0, 5, beats, dones, cycles);
        chk("f2_beats", 64'(beats), 64'(NPIX));
        chk("f2_dones", 64'(dones), 64'd1);

        // Eof pixel stalled three cycles in DRAIN.
        stream(2, -1, beats, dones, cycles);
        chk("f3_beats", 64'(beats), 64'(NPIX));
        chk("f3_dones", 64'(dones), 64'd1);
        chk("f3_cycles", 64'(cycles), 64'(NPIX + 1 + 3));

        // Reset asserted while pixel 7 is on the output.
        frame_start = 1'b1;
        pix_ready   = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (frame_done) dones++;
        end
        chk("pre_rst_pix7_x", {32'd0, pix_x}, 64'd3);
        chk("pre_rst_pix7_y", {32'd0, pix_y}, 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("midrst_valid_busy", {62'd0, pix_valid, busy}, 64'd0);
        chk("midrst_pix_xy", {pix_x, pix_y}, 64'd0);
        chk("midrst_scan", {scan_x, scan_y}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            if (frame_done) dones++;
            @(negedge clk);
        end
        chk("midrst_no_done", 64'(dones), 64'd0);
        chk("midrst_idle", {62'd0, pix_valid, busy}, 64'd0);

        stream(0, -1, beats, dones, cycles);
        chk("f4_beats", 64'(beats), 64'(NPIX));
        chk("f4_dones", 64'(dones), 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
